// File: rtl/rr_bus_arbiter.sv
// Round-robin owner arbiter for one shared bus port: registered one-hot grant plus binary owner index.
// Grant appears one cycle after request; owner keeps the bus until done, request drop, or hold limit.
module rr_bus_arbiter #(
  parameter int NREQ     = 4,
  parameter int IDX_W    = 2,
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [NREQ-1:0]  req,
  input  logic             done,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  logic             found;
  logic [IDX_W-1:0] winner;
  logic [IDX_W:0]   cand;
  logic [NREQ-1:0]  req_sh;
  logic             own_req;
  logic             at_limit;
  logic             release_own;
  logic [IDX_W-1:0] ptr_next;

  // Scan ptr, ptr+1, ... with explicit wrap so non-power-of-2 NREQ works.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    req_sh = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr_q} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NREQ)) begin
        cand = cand - (IDX_W+1)'(NREQ);
      end
      req_sh = req >> cand;
      if (!found && req_sh[0]) begin
        found  = 1'b1;
        winner = cand[IDX_W-1:0];
      end
    end
  end

  assign own_req     = |(req & gnt_q);
  assign at_limit    = (cnt_q == CNT_W'(MAX_HOLD - 1));
  assign release_own = done || !own_req || at_limit;
  assign ptr_next    = (idx_q == IDX_W'(NREQ - 1)) ? '0 : idx_q + 1'b1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      idx_q     <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = OWN;
          gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << winner;
          idx_d   = winner;
          cnt_d   = '0;
        end
      end
      OWN: begin
        cnt_d = cnt_q + 1'b1;
        if (release_own) begin
          state_d   = IDLE;
          gnt_d     = '0;
          ptr_d     = ptr_next;
          cnt_d     = '0;
          // Only a pure hold-limit release counts as a forced revoke.
          timeout_d = !done && own_req && at_limit;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt       = gnt_q;
    gnt_idx   = idx_q;
    gnt_valid = (state_q == OWN);
    timeout   = timeout_q;
  end

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Directed bench for rr_bus_arbiter (NREQ=4, MAX_HOLD=16): vector table plus hand-written corner sequences.
module tb_rr_bus_arbiter;

  logic       clk = 1'b0;
  logic       resetn;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int checks = 0;
  int failures = 0;

  rr_bus_arbiter #(.NREQ(4), .IDX_W(2), .MAX_HOLD(16), .CNT_W(16)) dut (
    .clk(clk), .resetn(resetn), .req(req), .done(done),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       vld;
    logic       to;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [3:0] r, input logic d, input logic [3:0] g, input logic [1:0] i);
    vec_t v;
    v.req = r; v.done = d; v.gnt = g; v.idx = i; v.vld = (g != 4'b0000); v.to = 1'b0;
    vq.push_back(v);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string name, input logic [3:0] g, input logic [1:0] i,
                         input logic v, input logic t);
    chk({name, ".gnt"}, 32'(gnt), 32'(g));
    chk({name, ".idx"}, 32'(gnt_idx), 32'(i));
    chk({name, ".vld"}, 32'(gnt_valid), 32'(v));
    chk({name, ".timeout"}, 32'(timeout), 32'(t));
  endtask

  initial begin
    // Round-robin with done in the second owned cycle, then skip/wrap, abandon, idle.
    add(4'b1111, 0, 4'b0001, 0); add(4'b1111, 0, 4'b0001, 0); add(4'b1111, 1, 4'b0000, 0);
    add(4'b1111, 0, 4'b0010, 1); add(4'b1111, 0, 4'b0010, 1); add(4'b1111, 1, 4'b0000, 1);
    add(4'b1111, 0, 4'b0100, 2); add(4'b1111, 0, 4'b0100, 2); add(4'b1111, 1, 4'b0000, 2);
    add(4'b1111, 0, 4'b1000, 3); add(4'b1111, 0, 4'b1000, 3); add(4'b1111, 1, 4'b0000, 3);
    add(4'b1111, 0, 4'b0001, 0); add(4'b1111, 1, 4'b0000, 0);
    add(4'b1111, 0, 4'b0010, 1); add(4'b1111, 0, 4'b0010, 1); add(4'b1111, 1, 4'b0000, 1);
    add(4'b1111, 0, 4'b0100, 2); add(4'b1111, 1, 4'b0000, 2);
    add(4'b0011, 0, 4'b0001, 0); add(4'b0011, 1, 4'b0000, 0);
    add(4'b0011, 0, 4'b0010, 1); add(4'b0011, 0, 4'b0010, 1);
    add(4'b0001, 0, 4'b0000, 1);
    add(4'b1111, 0, 4'b0100, 2); add(4'b1111, 1, 4'b0000, 2);
    add(4'b0000, 1, 4'b0000, 2); add(4'b0000, 0, 4'b0000, 2);

    resetn = 1'b0; req = 4'b1111; done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    resetn = 1'b1;

    for (int k = 0; k < vq.size(); k++) begin
      req  = vq[k].req;
      done = vq[k].done;
      step();
      chk_all($sformatf("vec%0d", k), vq[k].gnt, vq[k].idx, vq[k].vld, vq[k].to);
    end
    done = 1'b0;

    // Forced release after exactly 16 owned cycles, then regrant after one idle cycle.
    req = 4'b0100;
    for (int k = 0; k < 16; k++) begin
      step();
      chk_all($sformatf("hold%0d", k), 4'b0100, 2'd2, 1'b1, 1'b0);
    end
    step();
    chk_all("timeout_rel", 4'b0000, 2'd2, 1'b0, 1'b1);
    step();
    chk_all("regrant", 4'b0100, 2'd2, 1'b1, 1'b0);

    // done coinciding with the hold limit is a normal release.
    for (int k = 0; k < 15; k++) begin
      step();
      chk($sformatf("col_hold%0d.gnt", k), 32'(gnt), 32'(4'b0100));
    end
    done = 1'b1;
    step();
    chk_all("collision", 4'b0000, 2'd2, 1'b0, 1'b0);
    done = 1'b0; req = 4'b0000;
    step();
    chk_all("post_collision", 4'b0000, 2'd2, 1'b0, 1'b0);

    // Asynchronous reset drops the grant mid-cycle and clears the pointer.
    req = 4'b1000;
    step();
    chk_all("own3", 4'b1000, 2'd3, 1'b1, 1'b0);
    #2 resetn = 1'b0;
    #1;
    chk_all("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    step();
    resetn = 1'b1; req = 4'b1001;
    step();
    chk_all("after_rst", 4'b0001, 2'd0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_bus_arbiter.md
Name: rr_bus_arbiter

Overview:
Round-robin arbiter that shares one bus/resource port (e.g. the data-memory port) among NREQ requesters. It issues a registered one-hot grant plus the binary owner index. Downstream muxes use the binary index directly; the one-hot grant is what the decoder blocks would otherwise produce. The grant is held until the owner signals completion, drops its request, or exceeds a hold limit. It sits between the pipeline/cache requesters and the shared bus interface.

Parameters:
NREQ, 4, number of requesters; legal range 2..64, need not be a power of 2.
IDX_W, 2, width of the owner index; must satisfy 2**IDX_W >= NREQ.
MAX_HOLD, 16, maximum cycles a grant may be held; legal range 2..65535.
CNT_W, 16, width of the hold counter; must satisfy 2**CNT_W > MAX_HOLD.

Ports:
clk  input  1  clock; all state updates on the rising edge.
resetn  input  1  asynchronous active-low reset.
req  input  NREQ  per-requester request level; a requester holds it until its transaction is done.
done  input  1  current owner's transaction complete; single-cycle pulse, sampled only in OWN.
gnt  output  NREQ  registered one-hot grant; all zero when nobody owns the bus.
gnt_idx  output  IDX_W  binary index of the current owner; holds the last owner while idle.
gnt_valid  output  1  high while in OWN; equals |gnt.
timeout  output  1  one-cycle pulse when a grant is forcibly revoked.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - state=IDLE; gnt=0; gnt_idx=0; gnt_valid=0; timeout=0; hold counter=0; priority pointer ptr=0.
  - Reset mid-grant drops gnt immediately (asynchronously).
- States: IDLE, OWN.
- IDLE:
  - If req!=0, select the first set bit scanning ptr, ptr+1, ... NREQ-1, 0, ... ptr-1.
  - Next edge: state=OWN, gnt=one-hot(winner), gnt_idx=winner, hold counter=0.
  - If req==0, stay in IDLE; gnt stays 0.
  - done is ignored in IDLE.
- Latency: req rising in cycle t (state IDLE) -> gnt visible in cycle t+1.
- OWN: gnt and gnt_idx are stable; the hold counter increments by 1 each cycle.
- Release conditions, evaluated in each OWN cycle in this priority order:
  1. done=1 -> normal release.
  2. req[gnt_idx]=0 -> abandon release; no timeout.
  3. Hold counter == MAX_HOLD-1 -> forced release; timeout=1 for the following cycle.
- On any release, next edge:
  - state=IDLE; gnt=0; gnt_valid=0.
  - ptr = (gnt_idx+1) mod NREQ, with explicit wrap when NREQ is not a power of 2.
  - gnt_idx keeps its value.
- Grant spacing:
  - At least one IDLE cycle (gnt=0) always separates two grants, as bus turnaround.
  - Maximum grant length is MAX_HOLD cycles.
- Simultaneous events:
  - done and hold-limit in the same cycle: treated as a normal release; timeout stays 0.
  - New requests arriving during OWN do not preempt the owner.
- Fairness: any continuously asserted req is granted within NREQ grant periods.
- timeout is high only in the single cycle after a forced release; otherwise 0.
- No combinational path from req or done to any output; all outputs are registered.

Test Plan:
- Reset check: hold resetn=0, req=4'b1111 -> gnt=0, gnt_valid=0, gnt_idx=0, timeout=0.
  - Release resetn -> gnt=4'b0001 one cycle later.
- Round-robin: req=4'b1111 held; pulse done 2 cycles after each grant.
  - Grant sequence 0001,0010,0100,1000,0001, each separated by one gnt=0 cycle.
- Skip and wrap: after owner 2 releases, req=4'b0011 -> gnt=4'b0001 (ptr=3 wraps to 0).
  - Then the next grant goes to 4'b0010.
- Abandon: owner 1 granted, req[1] drops at cycle 3 with done=0 -> gnt=0 next cycle, timeout=0, ptr=2.
- Timeout: MAX_HOLD=16, req=4'b0100, done never asserted.
  - gnt=4'b0100 for exactly 16 cycles, then gnt=0 with a single timeout pulse.
  - req still high -> regranted after one idle cycle.
- Collision: done asserted in hold cycle 15 (MAX_HOLD=16) -> release with timeout=0.
- Async reset mid-grant: resetn pulled low while gnt=4'b1000 -> gnt=0 immediately.
  - After release of reset, ptr=0, so with req=4'b1001 the next grant is 4'b0001.
